// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction ROM and fills the IF/ID register.
// An illegal fetch address latches a sticky fault that only reset clears.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W            = 64,
    parameter longint unsigned      INSTRUCT_MEM_SIZE = 1024,
    parameter logic [ADDR_W-1:0]    RESET_PC          = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    output logic              fault,
    output logic [31:0]       fetch_count
);

    typedef enum logic {RUN, FAULTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    // One extra bit so a PC near the top of the address space cannot wrap into range.
    logic [ADDR_W:0]   pc_end;
    logic              pc_bad;

    assign pc_end = {1'b0, pc_q} + (ADDR_W+1)'(3);
    assign pc_bad = (pc_q[1:0] != 2'b00) || (pc_end >= (ADDR_W+1)'(INSTRUCT_MEM_SIZE));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            FAULTED: begin
                if_valid_d = 1'b0;
            end
            default: begin
                if (br_taken) begin
                    pc_d       = br_target;
                    if_valid_d = 1'b0;
                end else if (pc_bad) begin
                    state_d    = FAULTED;
                    if_valid_d = 1'b0;
                end else if (flush) begin
                    pc_d       = pc_q + ADDR_W'(4);
                    if_valid_d = 1'b0;
                end else if (!stall) begin
                    // imem_instr is only sampled here, where the address is known to be legal.
                    if_pc_d       = pc_q;
                    if_instr_d    = imem_instr;
                    if_valid_d    = 1'b1;
                    pc_d          = pc_q + ADDR_W'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_pc_q       <= '0;
            if_instr_q    <= 32'h0;
            if_valid_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign if_valid    = if_valid_q;
    assign fault       = (state_q == FAULTED);
    assign fetch_count = fetch_count_q;

endmodule
